// File: rtl/coz_paket.sv
// Decode-stage shared types: RV32I opcodes, ALU/unit encodings, decoded-field bundle.
// Purely declarative; no timing or flow control of its own.
package coz_paket;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] MRET = 32'h3020_0073;

  typedef enum logic [4:0] {
    TOPLA, CIKAR, VE, VEYA, XOR, SLL, SRL, SRA, SLT, SLTU, LUI_GEC, AUIPC_TOPLA
  } islem_e;

  typedef enum logic [2:0] {ALU, BELLEK, DALLANMA, SISTEM} birim_e;

  typedef enum logic [2:0] {FMT_YOK, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} format_e;

  typedef struct packed {
    logic        gecerli;
    logic [31:0] ps;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] anlik;
    islem_e      islem;
    birim_e      birim;
    logic        yazmac_yaz;
    logic        bellek_oku;
    logic        bellek_yaz;
    logic [2:0]  bellek_f3;
    logic        dallanma;
    logic        jal;
    logic        jalr;
    logic        mret;
    logic        ongoru;
    logic        gecersiz;
  } cikis_t;

  // alt selects sub/sra; callers only raise it where the encoding allows
  function automatic islem_e alu_islem(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_islem = alt ? CIKAR : TOPLA;
      3'b001:  alu_islem = SLL;
      3'b010:  alu_islem = SLT;
      3'b011:  alu_islem = SLTU;
      3'b100:  alu_islem = XOR;
      3'b101:  alu_islem = alt ? SRA : SRL;
      3'b110:  alu_islem = VEYA;
      default: alu_islem = VE;
    endcase
  endfunction

endpackage

// File: rtl/anlik_uretici.sv
// Immediate generator: sign-extends the selected RV32I immediate format; purely combinational.
// No flow control; output follows buyruk_i/format_i in the same cycle.
module anlik_uretici
  import coz_paket::*;
(
  input  logic [31:7] buyruk_i,
  input  format_e     format_i,
  output logic [31:0] anlik_o
);

  always_comb begin
    case (format_i)
      FMT_I:   anlik_o = {{20{buyruk_i[31]}}, buyruk_i[31:20]};
      FMT_S:   anlik_o = {{20{buyruk_i[31]}}, buyruk_i[31:25], buyruk_i[11:7]};
      FMT_B:   anlik_o = {{19{buyruk_i[31]}}, buyruk_i[31], buyruk_i[7],
                          buyruk_i[30:25], buyruk_i[11:8], 1'b0};
      FMT_U:   anlik_o = {buyruk_i[31:12], 12'b0};
      FMT_J:   anlik_o = {{11{buyruk_i[31]}}, buyruk_i[31], buyruk_i[19:12],
                          buyruk_i[20], buyruk_i[30:21], 1'b0};
      default: anlik_o = '0;
    endcase
  end

endmodule

// File: rtl/coz_asamasi.sv
// Decode stage: RV32I+mret into registered execute fields, one cycle latency.
// durdur_i holds the output register; load-use raises durdur_o for one cycle; bosalt_i overrides both.
module coz_asamasi
  import coz_paket::*;
#(
  parameter logic [31:0] NOP_BUYRUK      = 32'h0000_0013,
  parameter int          ADRES_GENISLIGI = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       durdur_i,
  input  logic                       bosalt_i,
  input  logic [ADRES_GENISLIGI-1:0] ps_i,
  input  logic [31:0]                buyruk_i,
  input  logic                       ongoru_gecerli_i,
  output logic                       durdur_o,
  output logic                       gecerli_o,
  output logic [ADRES_GENISLIGI-1:0] ps_o,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [4:0]                 rd_o,
  output logic [ADRES_GENISLIGI-1:0] anlik_o,
  output islem_e                     islem_o,
  output birim_e                     birim_o,
  output logic                       yazmac_yaz_o,
  output logic                       bellek_oku_o,
  output logic                       bellek_yaz_o,
  output logic [2:0]                 bellek_f3_o,
  output logic                       dallanma_o,
  output logic                       jal_o,
  output logic                       jalr_o,
  output logic                       mret_o,
  output logic                       ongoru_gecerli_o,
  output logic                       gecersiz_buyruk_o
);

  localparam logic [0:0] NORMAL   = 1'b0;
  localparam logic [0:0] KABARCIK = 1'b1;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  format_e     fmt;
  logic [31:0] anlik;
  logic        rs1_kul, rs2_kul, rd_kul, gecersiz;
  cikis_t      coz, yukle, cikis_d, cikis_q;
  logic [0:0]  durum_d, durum_q;
  logic        tehlike;

  assign opcode = buyruk_i[6:0];
  assign f3     = buyruk_i[14:12];
  assign f7     = buyruk_i[31:25];

  anlik_uretici u_anlik (
    .buyruk_i (buyruk_i[31:7]),
    .format_i (fmt),
    .anlik_o  (anlik)
  );

  always_comb begin
    coz         = '0;
    fmt         = FMT_YOK;
    rs1_kul     = 1'b0;
    rs2_kul     = 1'b0;
    rd_kul      = 1'b0;
    gecersiz    = 1'b0;
    coz.gecerli = 1'b1;
    coz.ps      = ps_i;
    case (opcode)
      OP_R: begin
        rs1_kul   = 1'b1;
        rs2_kul   = 1'b1;
        rd_kul    = 1'b1;
        coz.islem = alu_islem(f3, f7[5]);
        gecersiz  = !((f7 == 7'b0000000) ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_I: begin
        rs1_kul   = 1'b1;
        rd_kul    = 1'b1;
        fmt       = FMT_I;
        coz.islem = alu_islem(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      gecersiz = (f7 != 7'b0000000);
        else if (f3 == 3'b101) gecersiz = !(f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OP_LOAD: begin
        rs1_kul        = 1'b1;
        rd_kul         = 1'b1;
        fmt            = FMT_I;
        coz.birim      = BELLEK;
        coz.bellek_oku = 1'b1;
        coz.bellek_f3  = f3;
        gecersiz       = (f3 inside {3'b011, 3'b110, 3'b111});
      end
      OP_STORE: begin
        rs1_kul        = 1'b1;
        rs2_kul        = 1'b1;
        fmt            = FMT_S;
        coz.birim      = BELLEK;
        coz.bellek_yaz = 1'b1;
        coz.bellek_f3  = f3;
        gecersiz       = (f3 >= 3'b011);
      end
      OP_BRANCH: begin
        rs1_kul      = 1'b1;
        rs2_kul      = 1'b1;
        fmt          = FMT_B;
        coz.birim    = DALLANMA;
        coz.dallanma = 1'b1;
      end
      OP_JAL: begin
        rd_kul    = 1'b1;
        fmt       = FMT_J;
        coz.birim = DALLANMA;
        coz.jal   = 1'b1;
      end
      OP_JALR: begin
        rs1_kul   = 1'b1;
        rd_kul    = 1'b1;
        fmt       = FMT_I;
        coz.birim = DALLANMA;
        coz.jalr  = 1'b1;
      end
      OP_LUI: begin
        rd_kul    = 1'b1;
        fmt       = FMT_U;
        coz.islem = LUI_GEC;
      end
      OP_AUIPC: begin
        rd_kul    = 1'b1;
        fmt       = FMT_U;
        coz.islem = AUIPC_TOPLA;
      end
      OP_SYSTEM: begin
        if (buyruk_i == MRET) begin
          coz.birim = SISTEM;
          coz.mret  = 1'b1;
        end else begin
          gecersiz = 1'b1;
        end
      end
      default: gecersiz = 1'b1;
    endcase
    coz.rs1        = rs1_kul ? buyruk_i[19:15] : 5'd0;
    coz.rs2        = rs2_kul ? buyruk_i[24:20] : 5'd0;
    coz.rd         = rd_kul  ? buyruk_i[11:7]  : 5'd0;
    coz.yazmac_yaz = rd_kul && (buyruk_i[11:7] != 5'd0);
    coz.ongoru     = ongoru_gecerli_i && (coz.dallanma || coz.jal);
    // Illegal encodings keep only valid/ps so execute can raise the trap
    if (gecersiz) begin
      coz          = '0;
      coz.gecerli  = 1'b1;
      coz.ps       = ps_i;
      coz.gecersiz = 1'b1;
    end
  end

  always_comb begin
    yukle       = coz;
    yukle.anlik = coz.gecersiz ? 32'd0 : anlik;
    if (buyruk_i == NOP_BUYRUK) yukle = '0;
  end

  // Unused operand fields are zero, so they can never equal a nonzero rd
  assign tehlike = (durum_q == NORMAL) && cikis_q.gecerli && cikis_q.bellek_oku &&
                   (cikis_q.rd != 5'd0) &&
                   ((coz.rs1 == cikis_q.rd) || (coz.rs2 == cikis_q.rd));

  assign durdur_o = tehlike && !bosalt_i;

  // The bubble enters on the hazard edge; KABARCIK covers the cycle the held consumer re-presents
  always_comb begin
    cikis_d = cikis_q;
    durum_d = durum_q;
    if (bosalt_i) begin
      cikis_d = '0;
      durum_d = NORMAL;
    end else if (durdur_i) begin
      cikis_d = cikis_q;
      durum_d = durum_q;
    end else if (tehlike) begin
      cikis_d = '0;
      durum_d = KABARCIK;
    end else begin
      cikis_d = yukle;
      durum_d = NORMAL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cikis_q <= '0;
      durum_q <= NORMAL;
    end else begin
      cikis_q <= cikis_d;
      durum_q <= durum_d;
    end
  end

  assign gecerli_o         = cikis_q.gecerli;
  assign ps_o              = cikis_q.ps;
  assign rs1_o             = cikis_q.rs1;
  assign rs2_o             = cikis_q.rs2;
  assign rd_o              = cikis_q.rd;
  assign anlik_o           = cikis_q.anlik;
  assign islem_o           = cikis_q.islem;
  assign birim_o           = cikis_q.birim;
  assign yazmac_yaz_o      = cikis_q.yazmac_yaz;
  assign bellek_oku_o      = cikis_q.bellek_oku;
  assign bellek_yaz_o      = cikis_q.bellek_yaz;
  assign bellek_f3_o       = cikis_q.bellek_f3;
  assign dallanma_o        = cikis_q.dallanma;
  assign jal_o             = cikis_q.jal;
  assign jalr_o            = cikis_q.jalr;
  assign mret_o            = cikis_q.mret;
  assign ongoru_gecerli_o  = cikis_q.ongoru;
  assign gecersiz_buyruk_o = cikis_q.gecersiz;

endmodule

// File: tb/tb_coz_asamasi.sv
// Bench for the decode stage: scoreboard of expected register contents per driven instruction.
module tb_coz_asamasi;

  localparam logic [4:0] I_TOPLA = 5'd0, I_SRA = 5'd7, I_LUI = 5'd10;
  localparam logic [2:0] B_ALU = 3'd0, B_BELLEK = 3'd1, B_DAL = 3'd2, B_SIS = 3'd3;
  localparam logic [31:0] NOP = 32'h0000_0013, LW = 32'h0001_2303, ADD = 32'h0013_03B3;

  logic        clk_i = 1'b0, rst_i = 1'b0, durdur_i = 1'b0, bosalt_i = 1'b0;
  logic        ongoru_gecerli_i = 1'b0;
  logic [31:0] ps_i = '0, buyruk_i = 32'h0000_0013;
  logic        durdur_o, gecerli_o, yazmac_yaz_o, bellek_oku_o, bellek_yaz_o;
  logic        dallanma_o, jal_o, jalr_o, mret_o, ongoru_gecerli_o, gecersiz_buyruk_o;
  logic [31:0] ps_o, anlik_o;
  logic [4:0]  rs1_o, rs2_o, rd_o, islem_o;
  logic [2:0]  birim_o, bellek_f3_o;

  typedef struct packed {
    logic gecerli; logic [31:0] ps; logic [4:0] rs1, rs2, rd; logic [31:0] anlik;
    logic [4:0] islem; logic [2:0] birim; logic yaz, oku, yazb; logic [2:0] f3;
    logic dal, jal, jalr, mret, ong, gecersiz;
  } gozlem_t;

  gozlem_t sb[$];
  gozlem_t b, g;
  int compared = 0, mismatched = 0;

  always #5 clk_i = ~clk_i;

  coz_asamasi dut (
    .clk_i(clk_i), .rst_i(rst_i), .durdur_i(durdur_i), .bosalt_i(bosalt_i),
    .ps_i(ps_i), .buyruk_i(buyruk_i), .ongoru_gecerli_i(ongoru_gecerli_i),
    .durdur_o(durdur_o), .gecerli_o(gecerli_o), .ps_o(ps_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .anlik_o(anlik_o),
    .islem_o(islem_o), .birim_o(birim_o), .yazmac_yaz_o(yazmac_yaz_o),
    .bellek_oku_o(bellek_oku_o), .bellek_yaz_o(bellek_yaz_o), .bellek_f3_o(bellek_f3_o),
    .dallanma_o(dallanma_o), .jal_o(jal_o), .jalr_o(jalr_o), .mret_o(mret_o),
    .ongoru_gecerli_o(ongoru_gecerli_o), .gecersiz_buyruk_o(gecersiz_buyruk_o)
  );

  function automatic gozlem_t gozle();
    gozlem_t o;
    o = '{gecerli: gecerli_o, ps: ps_o, rs1: rs1_o, rs2: rs2_o, rd: rd_o, anlik: anlik_o,
          islem: islem_o, birim: birim_o, yaz: yazmac_yaz_o, oku: bellek_oku_o,
          yazb: bellek_yaz_o, f3: bellek_f3_o, dal: dallanma_o, jal: jal_o, jalr: jalr_o,
          mret: mret_o, ong: ongoru_gecerli_o, gecersiz: gecersiz_buyruk_o};
    return o;
  endfunction

  function automatic gozlem_t yeni(input logic [31:0] ps);
    gozlem_t o;
    o = '0;
    o.gecerli = 1'b1;
    o.ps = ps;
    return o;
  endfunction

  task automatic sur(input logic [31:0] buyruk, input logic [31:0] ps, input logic ong);
    buyruk_i = buyruk;
    ps_i = ps;
    ongoru_gecerli_i = ong;
  endtask

  task automatic kenar();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    sur(32'hFFC0_8293, 32'h10, 1'b0);
    #2;
    sb.push_back('0); b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL reset_state: got %h want %h", g, b); end
    compared++;
    if (durdur_o !== 1'b0) begin mismatched++; $display("FAIL reset_durdur: got %b want 0", durdur_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    sur(NOP, 32'h14, 1'b1);
    sb.push_back('0);
    kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL reset_bubble: got %h want %h", g, b); end
    sur(32'hFFC0_8293, 32'h18, 1'b0);
    kenar();
    #2 rst_i = 1'b0;
    #1;
    sb.push_back('0); b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL reset_async: got %h want %h", g, b); end
    #1 rst_i = 1'b1;
    sur(NOP, 32'h0, 1'b0);
    kenar();
  endtask

  task automatic test_addi();
    sur(32'hFFC0_8293, 32'h100, 1'b1);
    b = yeni(32'h100); b.rs1 = 5'd1; b.rd = 5'd5; b.anlik = 32'hFFFF_FFFC;
    b.islem = I_TOPLA; b.birim = B_ALU; b.yaz = 1'b1;
    sb.push_back(b);
    kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL addi: got %h want %h", g, b); end
  endtask

  task automatic test_load_use();
    gozlem_t lw_b;
    lw_b = yeni(32'h200); lw_b.rs1 = 5'd2; lw_b.rd = 5'd6; lw_b.birim = B_BELLEK;
    lw_b.yaz = 1'b1; lw_b.oku = 1'b1; lw_b.f3 = 3'b010;
    sur(LW, 32'h200, 1'b0); sb.push_back(lw_b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL lw: got %h want %h", g, b); end
    sur(ADD, 32'h204, 1'b0);
    #1; compared++;
    if (durdur_o !== 1'b1) begin mismatched++; $display("FAIL loaduse_stall: got %b want 1", durdur_o); end
    sb.push_back('0); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL loaduse_bubble: got %h want %h", g, b); end
    compared++;
    if (durdur_o !== 1'b0) begin mismatched++; $display("FAIL loaduse_one_cycle: got %b want 0", durdur_o); end
    b = yeni(32'h204); b.rs1 = 5'd6; b.rs2 = 5'd1; b.rd = 5'd7; b.yaz = 1'b1;
    sb.push_back(b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL add_issue: got %h want %h", g, b); end
    lw_b.ps = 32'h208;
    sur(LW, 32'h208, 1'b0); sb.push_back(lw_b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL lw2: got %h want %h", g, b); end
    sur(32'h1234_5337, 32'h20C, 1'b0);
    #1; compared++;
    if (durdur_o !== 1'b0) begin mismatched++; $display("FAIL lui_no_stall: got %b want 0", durdur_o); end
    b = yeni(32'h20C); b.rd = 5'd6; b.anlik = 32'h1234_5000; b.islem = I_LUI; b.yaz = 1'b1;
    sb.push_back(b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL lui: got %h want %h", g, b); end
  endtask

  task automatic test_hold_flush();
    gozlem_t lw_b;
    lw_b = yeni(32'h300); lw_b.rs1 = 5'd2; lw_b.rd = 5'd6; lw_b.birim = B_BELLEK;
    lw_b.yaz = 1'b1; lw_b.oku = 1'b1; lw_b.f3 = 3'b010;
    sur(LW, 32'h300, 1'b0); sb.push_back(lw_b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL lw3: got %h want %h", g, b); end
    sur(ADD, 32'h304, 1'b0); durdur_i = 1'b1;
    #1; compared++;
    if (durdur_o !== 1'b1) begin mismatched++; $display("FAIL hold_stall: got %b want 1", durdur_o); end
    sb.push_back(lw_b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL hold_keeps: got %h want %h", g, b); end
    compared++;
    if (dut.durum_q !== 1'b0) begin mismatched++; $display("FAIL hold_fsm: got %b want 0", dut.durum_q); end
    bosalt_i = 1'b1;
    #1; compared++;
    if (durdur_o !== 1'b0) begin mismatched++; $display("FAIL flush_durdur: got %b want 0", durdur_o); end
    sb.push_back('0); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL flush_bubble: got %h want %h", g, b); end
    compared++;
    if (dut.durum_q !== 1'b0) begin mismatched++; $display("FAIL flush_fsm: got %b want 0", dut.durum_q); end
    bosalt_i = 1'b0; durdur_i = 1'b0;
  endtask

  task automatic test_branch_sys();
    sur(32'hFE20_8CE3, 32'h400, 1'b1);
    b = yeni(32'h400); b.rs1 = 5'd1; b.rs2 = 5'd2; b.anlik = 32'hFFFF_FFF8;
    b.birim = B_DAL; b.dal = 1'b1; b.ong = 1'b1;
    sb.push_back(b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL beq: got %h want %h", g, b); end
    sur(32'h0000_0000, 32'h404, 1'b1);
    b = yeni(32'h404); b.gecersiz = 1'b1;
    sb.push_back(b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL illegal_zero: got %h want %h", g, b); end
    sur(32'h3020_0073, 32'h408, 1'b0);
    b = yeni(32'h408); b.mret = 1'b1; b.birim = B_SIS;
    sb.push_back(b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL mret: got %h want %h", g, b); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] kod [7];
    logic        ong [7];
    gozlem_t     bek [7];
    kod[0] = 32'h4031_50B3; ong[0] = 1'b0;
    bek[0] = yeni(32'h600); bek[0].rs1 = 5'd2; bek[0].rs2 = 5'd3; bek[0].rd = 5'd1;
    bek[0].islem = I_SRA; bek[0].yaz = 1'b1;
    kod[1] = 32'h4031_10B3; ong[1] = 1'b0;
    bek[1] = yeni(32'h604); bek[1].gecersiz = 1'b1;
    kod[2] = 32'h0050_A423; ong[2] = 1'b1;
    bek[2] = yeni(32'h608); bek[2].rs1 = 5'd1; bek[2].rs2 = 5'd5; bek[2].anlik = 32'd8;
    bek[2].birim = B_BELLEK; bek[2].yazb = 1'b1; bek[2].f3 = 3'b010;
    kod[3] = 32'h0100_00EF; ong[3] = 1'b1;
    bek[3] = yeni(32'h60C); bek[3].rd = 5'd1; bek[3].anlik = 32'd16; bek[3].birim = B_DAL;
    bek[3].jal = 1'b1; bek[3].yaz = 1'b1; bek[3].ong = 1'b1;
    kod[4] = 32'h0001_3303; ong[4] = 1'b0;
    bek[4] = yeni(32'h610); bek[4].gecersiz = 1'b1;
    kod[5] = 32'h0010_8013; ong[5] = 1'b0;
    bek[5] = yeni(32'h614); bek[5].rs1 = 5'd1; bek[5].anlik = 32'd1;
    kod[6] = NOP; ong[6] = 1'b1;
    bek[6] = '0;
    for (int i = 0; i < 7; i++) begin
      sur(kod[i], 32'h600 + 32'(4 * i), ong[i]);
      sb.push_back(bek[i]);
      kenar();
      b = sb.pop_front(); g = gozle(); compared++;
      if (g !== b) begin mismatched++; $display("FAIL b2b_%0d: got %h want %h", i, g, b); end
    end
  endtask

  task automatic test_reset_mid_stall();
    b = yeni(32'h700); b.rs1 = 5'd2; b.rd = 5'd6; b.birim = B_BELLEK;
    b.yaz = 1'b1; b.oku = 1'b1; b.f3 = 3'b010;
    sur(LW, 32'h700, 1'b0); sb.push_back(b); kenar();
    b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL lw4: got %h want %h", g, b); end
    sur(ADD, 32'h704, 1'b0); kenar();
    compared++;
    if (dut.durum_q !== 1'b1) begin mismatched++; $display("FAIL stall_fsm: got %b want 1", dut.durum_q); end
    #2 rst_i = 1'b0;
    #1; compared++;
    if (dut.durum_q !== 1'b0) begin mismatched++; $display("FAIL reset_fsm: got %b want 0", dut.durum_q); end
    sb.push_back('0); b = sb.pop_front(); g = gozle(); compared++;
    if (g !== b) begin mismatched++; $display("FAIL reset_stall_out: got %h want %h", g, b); end
    #1 rst_i = 1'b1;
    sur(NOP, 32'h0, 1'b0);
    kenar();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_hold_flush();
    test_branch_sys();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
